// File: rtl/text_cursor_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_cursor_writer_if
//  Description : Bundles the ASCII input handshake, the character-RAM write
//                port and the cursor status outputs of text_cursor_writer.
//  Ports       : ascii_in/ascii_valid/ascii_ready - character handshake
//                wr_en/wr_addr/wr_data            - character RAM write port
//                cursor_col/cursor_row            - cursor cell position
//                x_desired/y_desired              - cursor pixel position
//                cursor_visible                   - cursor blink phase
//  Modports    : master - character producer and consumer of the write port
//                slave  - the text_cursor_writer block
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_cursor_writer_if;
  logic [6:0]  ascii_in;
  logic        ascii_valid;
  logic        ascii_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [9:0]  x_desired;
  logic [9:0]  y_desired;
  logic        cursor_visible;

  modport master (
    output ascii_in, ascii_valid,
    input  ascii_ready, wr_en, wr_addr, wr_data,
    input  cursor_col, cursor_row, x_desired, y_desired, cursor_visible
  );

  modport slave (
    input  ascii_in, ascii_valid,
    output ascii_ready, wr_en, wr_addr, wr_data,
    output cursor_col, cursor_row, x_desired, y_desired, cursor_visible
  );
endinterface
`default_nettype wire

// File: rtl/text_cursor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_cursor_writer
//  Description : Producer side of the 640x480 text path. Clears the character
//                RAM to spaces, then writes incoming printable ASCII codes at
//                the cursor cell and advances the cursor. Handles LF/CR, BS
//                and FF (screen clear). Exports the cursor as pixel coords.
//  Ports       : clk    - system clock
//                reset  - synchronous, active-high reset
//                bus    - text_cursor_writer_if.slave (handshake, RAM write
//                         port, cursor position/visibility)
//  Options     : CURSOR_BLINK_EN - when defined, cursor_visible toggles every
//                BLINK_CYCLES clocks and is forced high on each cursor move.
//                Otherwise cursor_visible is tied high.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_cursor_writer #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  text_cursor_writer_if.slave  bus
);

  localparam logic [11:0] c_cells    = 12'(COLS * ROWS);
  localparam logic [6:0]  c_last_col = 7'(COLS - 1);
  localparam logic [4:0]  c_last_row = 5'(ROWS - 1);
  localparam logic [6:0]  c_space    = 7'h20;
  localparam logic [6:0]  c_tilde    = 7'h7E;
  localparam logic [6:0]  c_bs       = 7'h08;
  localparam logic [6:0]  c_lf       = 7'h0A;
  localparam logic [6:0]  c_ff       = 7'h0C;
  localparam logic [6:0]  c_cr       = 7'h0D;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  code_q, code_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [6:0]  wr_data_q, wr_data_d;
  logic        ready_q, ready_d;

  // Linear RAM address of the current cursor cell.
  logic [11:0] cell_addr;
  logic        at_origin;
  logic [4:0]  row_next;

  assign cell_addr = 12'(row_q) * 12'(COLS) + 12'(col_q);
  assign at_origin = (col_q == 7'd0) && (row_q == 5'd0);
  // No scrolling: moving past the last row wraps to the top.
  assign row_next  = (row_q == c_last_row) ? 5'd0 : row_q + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= 12'd0;
      col_q     <= 7'd0;
      row_q     <= 5'd0;
      code_q    <= 7'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 12'd0;
      wr_data_q <= c_space;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      code_q    <= code_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
    end
  end

  // The RAM write port is registered, so the write for a cycle is decided one
  // cycle ahead: CLEAR issues address cnt_q for the following cycle, and the
  // IDLE accept decision issues the write that appears during EXEC.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    code_d    = code_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ready_d   = 1'b0;

    case (state_q)
      CLEAR: begin
        if (cnt_q == c_cells) begin
          // Final space write is on the port this cycle.
          state_d = IDLE;
          ready_d = 1'b1;
          col_d   = 7'd0;
          row_d   = 5'd0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = c_space;
          cnt_d     = cnt_q + 12'd1;
        end
      end

      IDLE: begin
        ready_d = 1'b1;
        if (bus.ascii_valid && ready_q) begin
          code_d  = bus.ascii_in;
          state_d = EXEC;
          ready_d = 1'b0;
          if (bus.ascii_in >= c_space && bus.ascii_in <= c_tilde) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr;
            wr_data_d = bus.ascii_in;
          end else if (bus.ascii_in == c_bs && !at_origin) begin
            // Either back one column or to the end of the previous row;
            // both land on the linear address just before the cursor.
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr - 12'd1;
            wr_data_d = c_space;
          end
        end
      end

      EXEC: begin
        state_d = IDLE;
        ready_d = 1'b1;
        if (code_q >= c_space && code_q <= c_tilde) begin
          if (col_q == c_last_col) begin
            col_d = 7'd0;
            row_d = row_next;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else if (code_q == c_lf || code_q == c_cr) begin
          col_d = 7'd0;
          row_d = row_next;
        end else if (code_q == c_bs) begin
          if (col_q != 7'd0) begin
            col_d = col_q - 7'd1;
          end else if (row_q != 5'd0) begin
            col_d = c_last_col;
            row_d = row_q - 5'd1;
          end
        end else if (code_q == c_ff) begin
          state_d = CLEAR;
          ready_d = 1'b0;
          cnt_d   = 12'd0;
        end
      end

      default: begin
        state_d = CLEAR;
        cnt_d   = 12'd0;
      end
    endcase
  end

  assign bus.ascii_ready = ready_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.cursor_col  = col_q;
  assign bus.cursor_row  = row_q;
  assign bus.x_desired   = {col_q, 3'b000};
  assign bus.y_desired   = {1'b0, row_q, 4'b0000};

`ifdef CURSOR_BLINK_EN
  logic [31:0] blink_cnt_q;
  logic        visible_q;
  logic        cursor_move;

  assign cursor_move = (col_d != col_q) || (row_d != row_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= 32'd0;
      visible_q   <= 1'b1;
    end else if (cursor_move) begin
      // Keep the cursor solid while the user is typing.
      blink_cnt_q <= 32'd0;
      visible_q   <= 1'b1;
    end else if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= 32'd0;
      visible_q   <= ~visible_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 32'd1;
    end
  end

  assign bus.cursor_visible = visible_q;
`else
  assign bus.cursor_visible = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_cursor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_cursor_writer
//  Description : Self-checking bench for text_cursor_writer. Expected RAM
//                writes are queued when characters are sent and compared as
//                the DUT issues them; cursor state is checked after each one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_cursor_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic clk;
  logic reset;

  text_cursor_writer_if bus ();

  text_cursor_writer #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .BLINK_CYCLES (25_000_000)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;

  // Each entry is {addr, data}.
  logic [18:0] sb[$];

  // Bench-side cursor model.
  int m_col = 0;
  int m_row = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Write monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      logic [18:0] exp_wr;
      wr_cnt++;
      check("ready_low_on_wr", 32'(bus.ascii_ready), 32'd0);
      check("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_wr = sb.pop_front();
        check("wr_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'(exp_wr));
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < COLS * ROWS; i++) sb.push_back({12'(i), 7'h20});
    m_col = 0;
    m_row = 0;
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 32'(bus.cursor_col), 32'(m_col));
    check({tag, "_row"}, 32'(bus.cursor_row), 32'(m_row));
    check({tag, "_x"},   32'(bus.x_desired),  32'(m_col * 8));
    check({tag, "_y"},   32'(bus.y_desired),  32'(m_row * 16));
    check({tag, "_vis"}, 32'(bus.cursor_visible), 32'd1);
  endtask

  // Wait for all queued clear writes; ready must be up the cycle after the last.
  task automatic drain_clear(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    check({tag, "_ready"}, 32'(bus.ascii_ready), 32'd1);
    check({tag, "_wr_idle"}, 32'(bus.wr_en), 32'd0);
    check_cursor(tag);
  endtask

  task automatic check_reset_vals();
    check("rst_wr_en",   32'(bus.wr_en),       32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr),     32'd0);
    check("rst_wr_data", 32'(bus.wr_data),     32'h20);
    check("rst_ready",   32'(bus.ascii_ready), 32'd0);
    check_cursor("rst");
  endtask

  // Model the character, drive it, wait for acceptance and execution.
  task automatic send(input logic [6:0] c);
    int n = 0;
    bit is_ff = (c == 7'h0C);
    if (c >= 7'h20 && c <= 7'h7E) begin
      sb.push_back({12'(m_row * COLS + m_col), c});
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end else if (c == 7'h0A || c == 7'h0D) begin
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end else if (c == 7'h08) begin
      if (m_col > 0) begin
        m_col--;
        sb.push_back({12'(m_row * COLS + m_col), 7'h20});
      end else if (m_row > 0) begin
        m_col = COLS - 1;
        m_row--;
        sb.push_back({12'(m_row * COLS + m_col), 7'h20});
      end
    end else if (is_ff) begin
      push_clear();
    end

    @(posedge clk); #1;
    bus.ascii_valid = 1'b1;
    bus.ascii_in    = c;
    forever begin
      @(negedge clk);
      if (bus.ascii_ready === 1'b1) break;
      n++;
      if (n > 3000) begin
        check("handshake_timeout", 32'(n), 32'd0);
        bus.ascii_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.ascii_valid = 1'b0;
    bus.ascii_in    = 7'($urandom);
    @(posedge clk); #1;
    if (!is_ff) begin
      check("exec_ready", 32'(bus.ascii_ready), 32'd1);
      check("exec_wr_done", 32'(sb.size()), 32'd0);
      check_cursor("exec");
    end
  endtask

  initial begin
    int base;
    int n;
    reset           = 1'b1;
    bus.ascii_valid = 1'b0;
    bus.ascii_in    = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();

    // Power-up clear.
    push_clear();
    reset = 1'b0;
    drain_clear("clr0");

    // Single printable, then back over it.
    send(7'h41);
    send(7'h08);

    // Full line from 0/0 wraps to the next row.
    for (int i = 0; i < COLS; i++) send(7'(7'h20 + (i % 95)));

    // BS from col 0 row 1, then walk back to 0/0 and try once more.
    send(7'h08);
    for (int i = 0; i < COLS - 1; i++) send(7'h08);
    send(7'h08);

    // Unhandled control code: consumed, nothing happens.
    send(7'h07);

    // LF at col 5 of the last row wraps to 0/0.
    for (int i = 0; i < ROWS - 1; i++) send(7'h0A);
    for (int i = 0; i < 5; i++) send(7'h61);
    send(7'h0A);

    // Last cell write and wrap of both coordinates.
    for (int i = 0; i < ROWS - 1; i++) send(7'h0D);
    for (int i = 0; i < COLS - 1; i++) send(7'h2E);
    send(7'h42);

    // FF mid-line, then a character held valid through the whole clear.
    send(7'h31);
    send(7'h32);
    send(7'h0C);
    send(7'h5A);

    // FF with a full check of the clear.
    send(7'h33);
    send(7'h0C);
    drain_clear("clr_ff");

    // Reset at clear cycle 1000 restarts the clear from address 0.
    send(7'h0C);
    base = wr_cnt;
    n = 0;
    while (wr_cnt - base < 1000 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("midclr_reach_1000", 32'(wr_cnt - base >= 1000), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb.delete();
    check_reset_vals();
    push_clear();
    reset = 1'b0;
    drain_clear("clr_rst");

    send(7'h7E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Producer side of the on-screen text path for the 640x480 display.
- Accepts a stream of 7-bit ASCII characters (e.g. from the keyboard decoder) over a valid/ready handshake.
- Writes each printable character into the character buffer RAM at the current cursor cell, then advances the cursor.
- Cursor position is exported as pixel coordinates (x_desired, y_desired) for the character-cell text generator.

Parameters:
- COLS, 80, character columns per screen (640 / 8-pixel cell width)
- ROWS, 30, character rows per screen (480 / 16-pixel cell height)
- BLINK_CYCLES, 25_000_000, clk cycles per cursor blink half-period (used only with CURSOR_BLINK_EN)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ascii_in  input  7  incoming ASCII code
- ascii_valid  input  1  ascii_in is valid this cycle
- ascii_ready  output  1  block can accept a character this cycle
- wr_en  output  1  character RAM write strobe, one cycle wide
- wr_addr  output  12  RAM address = row*COLS + col
- wr_data  output  7  ASCII code to write
- cursor_col  output  7  current cursor column, 0..COLS-1
- cursor_row  output  5  current cursor row, 0..ROWS-1
- x_desired  output  10  cursor_col*8
- y_desired  output  10  cursor_row*16
- cursor_visible  output  1  cursor blink phase (constant 1 when feature off)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=7'h20, ascii_ready=0, cursor 0/0, x_desired=0, y_desired=0, cursor_visible=1, state=CLEAR, clear counter=0.
- States: CLEAR, IDLE, EXEC.
- CLEAR:
  - ascii_ready=0.
  - Each cycle: wr_en=1, wr_addr=counter, wr_data=7'h20; counter increments.
  - After address COLS*ROWS-1 (2399) is written: cursor set to 0/0, go to IDLE.
  - Exactly 2400 write cycles per clear.
- IDLE:
  - ascii_ready=1, wr_en=0.
  - On ascii_valid && ascii_ready: latch ascii_in, go to EXEC.
- EXEC (one cycle; ascii_ready=0; returns to IDLE unless noted). Action depends on the latched code:
  - 0x20..0x7E (printable): wr_en=1, wr_addr=row*COLS+col, wr_data=code; then advance the cursor.
  - Cursor advance: col+1. At col COLS-1, go to col 0, row+1. At row ROWS-1, row wraps to 0 (no scrolling).
  - 0x0A (LF) or 0x0D (CR): col=0, row+1 with the same wrap rule; no write.
  - 0x08 (BS), col>0: col-1, then write 0x20 at the new position.
  - 0x08 (BS), col==0 and row>0: move to col COLS-1, row-1, then write 0x20 there.
  - 0x08 (BS) at 0/0: no move, no write.
  - 0x0C (FF): no write; counter=0; go to CLEAR.
  - Any other code: consumed, no action.
- Timing:
  - Write address and data are computed from the cursor value before the update (BS: after the move).
  - Cursor outputs, x_desired and y_desired update at the end of the EXEC cycle.
  - Handshake-to-wr_en latency is 1 cycle; throughput is 1 character per 2 cycles.
- Outputs: all are registered or derived combinationally from registered state only. x_desired and y_desired are zero-extended shifts of the cursor values.
- Handshake: ascii_valid while ascii_ready=0 is ignored. The upstream producer holds the character until it is accepted.
- Reset mid-operation: reset during CLEAR or EXEC aborts the operation and restarts from the reset state, including a full new CLEAR.

Optional Feature:
- Macro CURSOR_BLINK_EN.
- Defined: a free-running counter toggles cursor_visible every BLINK_CYCLES clk cycles. The counter restarts and cursor_visible is forced to 1 on any cursor move, so the cursor is visible while typing.
- Not defined: cursor_visible tied to 1; no blink counter is synthesized.

Test Plan:
- Release reset -> exactly 2400 wr_en cycles, addr 0..2399 in order, data 0x20 each; ascii_ready rises on the next cycle; cursor 0/0.
- In IDLE, send 0x41 -> next cycle wr_en=1, addr=0, data=0x41; then cursor_col=1, x_desired=8, ascii_ready=1 one cycle later.
- Send 80 printable characters from 0/0 -> last write at addr 79; cursor becomes col 0 row 1, y_desired=16.
- At col 0 row 1, send 0x08 -> wr_en with addr 79, data 0x20; cursor col 79 row 0. A second 0x08 at 0/0 -> no write, cursor unchanged.
- Cursor at col 5 row 29, send 0x0A -> no write; cursor 0/0. Cursor at col 79 row 29, send 0x42 -> write addr 2399; cursor 0/0.
- Mid-line send 0x0C -> 2400 clear writes, cursor 0/0. Assert reset at clear cycle 1000 -> clear restarts at addr 0 after reset is released.
